// File: rtl/reservation_station_param_if.sv
// Dispatch, wakeup (CDB), issue and occupancy signals of the reservation station.
// The master drives dispatch/CDB/issue-accept; the slave is the station itself.
interface reservation_station_param_if #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 7,
  parameter int DATA_W = 32,
  parameter int OPC_W  = 7,
  parameter int PC_W   = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic [OPC_W-1:0]  disp_opcode;
  logic [PC_W-1:0]   disp_pc;
  logic [TAG_W-1:0]  disp_rd;
  logic [TAG_W-1:0]  disp_src1_tag;
  logic [TAG_W-1:0]  disp_src2_tag;
  logic [DATA_W-1:0] disp_src1_data;
  logic [DATA_W-1:0] disp_src2_data;
  logic              disp_src1_rdy;
  logic              disp_src2_rdy;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              iss_valid;
  logic              iss_ready;
  logic [OPC_W-1:0]  iss_opcode;
  logic [PC_W-1:0]   iss_pc;
  logic [TAG_W-1:0]  iss_rd;
  logic [DATA_W-1:0] iss_src1_data;
  logic [DATA_W-1:0] iss_src2_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, disp_valid, disp_opcode, disp_pc, disp_rd,
           disp_src1_tag, disp_src2_tag, disp_src1_data, disp_src2_data,
           disp_src1_rdy, disp_src2_rdy, cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  disp_ready, iss_valid, iss_opcode, iss_pc, iss_rd,
           iss_src1_data, iss_src2_data, count
  );

  modport slave (
    input  flush, disp_valid, disp_opcode, disp_pc, disp_rd,
           disp_src1_tag, disp_src2_tag, disp_src1_data, disp_src2_data,
           disp_src1_rdy, disp_src2_rdy, cdb_valid, cdb_tag, cdb_data, iss_ready,
    output disp_ready, iss_valid, iss_opcode, iss_pc, iss_rd,
           iss_src1_data, iss_src2_data, count
  );
endinterface

// File: rtl/reservation_station_param.sv
// Age-ordered collapsing reservation station: oldest-ready issue, CDB wakeup with
// dispatch bypass, compaction on issue.
module reservation_station_param #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 7,
  parameter int DATA_W = 32,
  parameter int OPC_W  = 7,
  parameter int PC_W   = 32
) (
  input logic clk,
  input logic reset,
  reservation_station_param_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [PC_W-1:0]   pc;
    logic [TAG_W-1:0]  rd;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_data;
    logic              s1_rdy;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_data;
    logic              s2_rdy;
  } entry_t;

  // A source already holding its value is never touched by a broadcast.
  function automatic entry_t wake_entry(input entry_t e, input logic cdb_v,
                                        input logic [TAG_W-1:0] tag,
                                        input logic [DATA_W-1:0] data);
    entry_t w;
    w = e;
    if (cdb_v && !e.s1_rdy && (e.s1_tag == tag)) begin
      w.s1_rdy  = 1'b1;
      w.s1_data = data;
    end else begin
      w.s1_rdy  = e.s1_rdy;
    end
    if (cdb_v && !e.s2_rdy && (e.s2_tag == tag)) begin
      w.s2_rdy  = 1'b1;
      w.s2_data = data;
    end else begin
      w.s2_rdy  = e.s2_rdy;
    end
    return w;
  endfunction

  entry_t            ent_r     [DEPTH];
  entry_t            ent_nxt_s [DEPTH];
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [DEPTH-1:0]  valid_s;
  logic [DEPTH-1:0]  cand_s;
  logic [DEPTH-1:0]  shift_s;
  logic              found_s;
  logic [IDX_W-1:0]  sel_idx_s;
  entry_t            sel_ent_s;
  entry_t            disp_raw_s;
  entry_t            disp_ent_s;
  logic              disp_ready_s;
  logic              disp_fire_s;
  logic              iss_fire_s;
  logic [CNT_W-1:0]  wr_idx_s;

  // Oldest-ready selection; scanning downward lets the lowest index win.
  always_comb begin
    found_s   = 1'b0;
    sel_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i] = (CNT_W'(i) < count_r);
      cand_s[i]  = valid_s[i] && ent_r[i].s1_rdy && ent_r[i].s2_rdy;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      sel_idx_s = cand_s[i] ? IDX_W'(i) : sel_idx_s;
      found_s   = found_s | cand_s[i];
    end
    sel_ent_s = found_s ? ent_r[sel_idx_s] : '0;
  end

  // Handshake qualification and the dispatched entry with CDB bypass applied.
  always_comb begin
    disp_ready_s = (count_r < CNT_W'(DEPTH));
    disp_fire_s  = bus.disp_valid && disp_ready_s;
    iss_fire_s   = found_s && bus.iss_ready;
    wr_idx_s     = count_r - {{(CNT_W-1){1'b0}}, iss_fire_s};
    disp_raw_s.opc     = bus.disp_opcode;
    disp_raw_s.pc      = bus.disp_pc;
    disp_raw_s.rd      = bus.disp_rd;
    disp_raw_s.s1_tag  = bus.disp_src1_tag;
    disp_raw_s.s1_data = bus.disp_src1_data;
    disp_raw_s.s1_rdy  = bus.disp_src1_rdy;
    disp_raw_s.s2_tag  = bus.disp_src2_tag;
    disp_raw_s.s2_data = bus.disp_src2_data;
    disp_raw_s.s2_rdy  = bus.disp_src2_rdy;
    disp_ent_s = wake_entry(disp_raw_s, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  // Next slot contents: compact above the issued slot, wake in the new slot, then append.
  always_comb begin
    shift_s = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      shift_s[i]   = iss_fire_s && (IDX_W'(i) >= sel_idx_s);
      ent_nxt_s[i] = shift_s[i]
                   ? wake_entry(ent_r[i+1], bus.cdb_valid && valid_s[i+1], bus.cdb_tag, bus.cdb_data)
                   : wake_entry(ent_r[i], bus.cdb_valid && valid_s[i], bus.cdb_tag, bus.cdb_data);
    end
    ent_nxt_s[DEPTH-1] = wake_entry(ent_r[DEPTH-1], bus.cdb_valid && valid_s[DEPTH-1],
                                    bus.cdb_tag, bus.cdb_data);
    for (int i = 0; i < DEPTH; i++) begin
      ent_nxt_s[i] = (disp_fire_s && (wr_idx_s == CNT_W'(i))) ? disp_ent_s : ent_nxt_s[i];
    end
    if (disp_fire_s && !iss_fire_s) begin
      count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (iss_fire_s && !disp_fire_s) begin
      count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State registers; flush drops every entry and discards that cycle's handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= '0;
      end
    end else if (bus.flush) begin
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i].s1_rdy <= 1'b0;
        ent_r[i].s2_rdy <= 1'b0;
      end
    end else begin
      count_r <= count_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        ent_r[i] <= ent_nxt_s[i];
      end
    end
  end

  assign bus.disp_ready    = disp_ready_s;
  assign bus.iss_valid     = found_s;
  assign bus.iss_opcode    = sel_ent_s.opc;
  assign bus.iss_pc        = sel_ent_s.pc;
  assign bus.iss_rd        = sel_ent_s.rd;
  assign bus.iss_src1_data = sel_ent_s.s1_data;
  assign bus.iss_src2_data = sel_ent_s.s2_data;
  assign bus.count         = count_r;
endmodule

// File: tb/tb_reservation_station_param.sv
// Directed bench for reservation_station_param: one task per scenario, inline checks.
module tb_reservation_station_param;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  reservation_station_param_if #(.DEPTH(16), .TAG_W(7), .DATA_W(32), .OPC_W(7), .PC_W(32)) bus ();

  reservation_station_param #(.DEPTH(16), .TAG_W(7), .DATA_W(32), .OPC_W(7), .PC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0;          bus.disp_valid = 1'b0;
    bus.disp_opcode = 7'd0;    bus.disp_pc = 32'd0;        bus.disp_rd = 7'd0;
    bus.disp_src1_tag = 7'd0;  bus.disp_src2_tag = 7'd0;
    bus.disp_src1_data = 32'd0; bus.disp_src2_data = 32'd0;
    bus.disp_src1_rdy = 1'b0;  bus.disp_src2_rdy = 1'b0;
    bus.cdb_valid = 1'b0;      bus.cdb_tag = 7'd0;         bus.cdb_data = 32'd0;
    bus.iss_ready = 1'b0;
  endtask

  task automatic set_disp(input logic [6:0] rd, input logic [6:0] t1, input logic [31:0] d1,
                          input logic r1, input logic [6:0] t2, input logic [31:0] d2,
                          input logic r2);
    bus.disp_valid = 1'b1;
    bus.disp_opcode = rd + 7'd1;
    bus.disp_pc = 32'h1000 + {25'd0, rd};
    bus.disp_rd = rd;
    bus.disp_src1_tag = t1; bus.disp_src1_data = d1; bus.disp_src1_rdy = r1;
    bus.disp_src2_tag = t2; bus.disp_src2_data = d2; bus.disp_src2_rdy = r2;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #3;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", bus.count); end
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid: got %0b exp 0", bus.iss_valid); end
    checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %0b exp 1", bus.disp_ready); end
    checks++; if (bus.iss_src1_data !== 32'd0) begin errors++; $display("FAIL reset_iss_data: got %0h exp 0", bus.iss_src1_data); end
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    set_disp(7'd3, 7'd0, 32'd5, 1'b1, 7'd0, 32'd7, 1'b1);
    bus.iss_ready = 1'b1;
    step();
    bus.disp_valid = 1'b0;
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL basic_count1: got %0d exp 1", bus.count); end
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL basic_iss_valid: got %0b exp 1", bus.iss_valid); end
    checks++; if (bus.iss_src1_data !== 32'd5) begin errors++; $display("FAIL basic_src1: got %0h exp 5", bus.iss_src1_data); end
    checks++; if (bus.iss_src2_data !== 32'd7) begin errors++; $display("FAIL basic_src2: got %0h exp 7", bus.iss_src2_data); end
    checks++; if (bus.iss_rd !== 7'd3) begin errors++; $display("FAIL basic_rd: got %0d exp 3", bus.iss_rd); end
    checks++; if (bus.iss_opcode !== 7'd4) begin errors++; $display("FAIL basic_opcode: got %0d exp 4", bus.iss_opcode); end
    checks++; if (bus.iss_pc !== 32'h1003) begin errors++; $display("FAIL basic_pc: got %0h exp 1003", bus.iss_pc); end
    step();
    bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL basic_count0: got %0d exp 0", bus.count); end
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %0b exp 0", bus.iss_valid); end
    checks++; if (bus.iss_rd !== 7'd0) begin errors++; $display("FAIL basic_rd_zero: got %0d exp 0", bus.iss_rd); end
  endtask

  task automatic test_wakeup();
    set_disp(7'd10, 7'd9, 32'hdead, 1'b0, 7'd0, 32'd2, 1'b1);
    step();
    set_disp(7'd11, 7'd0, 32'd1, 1'b1, 7'd0, 32'd1, 1'b1);
    step();
    bus.disp_valid = 1'b0;
    checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL wake_count2: got %0d exp 2", bus.count); end
    checks++; if (bus.iss_rd !== 7'd11) begin errors++; $display("FAIL wake_b_first: got %0d exp 11", bus.iss_rd); end
    bus.iss_ready = 1'b1;
    step();
    bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL wake_count1: got %0d exp 1", bus.count); end
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL wake_a_waiting: got %0b exp 0", bus.iss_valid); end
    bus.cdb_valid = 1'b1; bus.cdb_tag = 7'd9; bus.cdb_data = 32'h1234;
    step();
    bus.cdb_valid = 1'b0;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL wake_a_ready: got %0b exp 1", bus.iss_valid); end
    checks++; if (bus.iss_rd !== 7'd10) begin errors++; $display("FAIL wake_a_rd: got %0d exp 10", bus.iss_rd); end
    checks++; if (bus.iss_src1_data !== 32'h1234) begin errors++; $display("FAIL wake_a_src1: got %0h exp 1234", bus.iss_src1_data); end
    checks++; if (bus.iss_src2_data !== 32'd2) begin errors++; $display("FAIL wake_a_src2: got %0h exp 2", bus.iss_src2_data); end
    bus.iss_ready = 1'b1;
    step();
    bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL wake_count0: got %0d exp 0", bus.count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      set_disp(7'(i), 7'(40 + i), 32'd0, 1'b0, 7'd0, 32'(i), 1'b1);
      step();
    end
    set_disp(7'd99, 7'd0, 32'd0, 1'b1, 7'd0, 32'd0, 1'b1);
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d exp 16", bus.count); end
    checks++; if (bus.disp_ready !== 1'b0) begin errors++; $display("FAIL full_disp_ready: got %0b exp 0", bus.disp_ready); end
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL full_none_ready: got %0b exp 0", bus.iss_valid); end
    step();
    bus.disp_valid = 1'b0;
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL full_17th_ignored: got %0d exp 16", bus.count); end
    bus.cdb_valid = 1'b1; bus.cdb_tag = 7'd45; bus.cdb_data = 32'h55;
    step();
    checks++; if (bus.iss_rd !== 7'd5) begin errors++; $display("FAIL full_wake5_rd: got %0d exp 5", bus.iss_rd); end
    checks++; if (bus.iss_src1_data !== 32'h55) begin errors++; $display("FAIL full_wake5_src1: got %0h exp 55", bus.iss_src1_data); end
    bus.iss_ready = 1'b1; bus.cdb_tag = 7'd47; bus.cdb_data = 32'h77;
    step();
    bus.iss_ready = 1'b0; bus.cdb_valid = 1'b0;
    checks++; if (bus.count !== 5'd15) begin errors++; $display("FAIL full_count15: got %0d exp 15", bus.count); end
    checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL full_disp_ready_back: got %0b exp 1", bus.disp_ready); end
    checks++; if (bus.iss_rd !== 7'd7) begin errors++; $display("FAIL full_shift_wake_rd: got %0d exp 7", bus.iss_rd); end
    checks++; if (bus.iss_src1_data !== 32'h77) begin errors++; $display("FAIL full_shift_wake_src1: got %0h exp 77", bus.iss_src1_data); end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL full_flushed: got %0d exp 0", bus.count); end
  endtask

  task automatic test_bypass();
    set_disp(7'd12, 7'd4, 32'h11, 1'b1, 7'd4, 32'hdead, 1'b0);
    bus.cdb_valid = 1'b1; bus.cdb_tag = 7'd4; bus.cdb_data = 32'hbeef;
    step();
    bus.disp_valid = 1'b0; bus.cdb_valid = 1'b0;
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %0b exp 1", bus.iss_valid); end
    checks++; if (bus.iss_src2_data !== 32'hbeef) begin errors++; $display("FAIL bypass_src2: got %0h exp beef", bus.iss_src2_data); end
    checks++; if (bus.iss_src1_data !== 32'h11) begin errors++; $display("FAIL bypass_src1_kept: got %0h exp 11", bus.iss_src1_data); end
    bus.iss_ready = 1'b1;
    step();
    bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL bypass_issued: got %0d exp 0", bus.count); end
  endtask

  task automatic test_back_to_back();
    set_disp(7'd21, 7'd0, 32'ha, 1'b1, 7'd0, 32'hb, 1'b1);
    step();
    bus.disp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.iss_rd !== 7'd21) begin errors++; $display("FAIL hold_rd[%0d]: got %0d exp 21", c, bus.iss_rd); end
      checks++; if (bus.iss_src1_data !== 32'ha) begin errors++; $display("FAIL hold_src1[%0d]: got %0h exp a", c, bus.iss_src1_data); end
      checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL hold_count[%0d]: got %0d exp 1", c, bus.count); end
      step();
    end
    bus.iss_ready = 1'b1;
    set_disp(7'd22, 7'd0, 32'hc, 1'b1, 7'd0, 32'hd, 1'b1);
    step();
    bus.disp_valid = 1'b0; bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL b2b_count: got %0d exp 1", bus.count); end
    checks++; if (bus.iss_rd !== 7'd22) begin errors++; $display("FAIL b2b_rd: got %0d exp 22", bus.iss_rd); end
    checks++; if (bus.iss_src2_data !== 32'hd) begin errors++; $display("FAIL b2b_src2: got %0h exp d", bus.iss_src2_data); end
    bus.iss_ready = 1'b1;
    step();
    bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL b2b_drain: got %0d exp 0", bus.count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_disp(7'(i + 1), 7'd0, 32'(i), 1'b1, 7'd0, 32'(i), 1'b1);
      step();
    end
    bus.disp_valid = 1'b0;
    checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL flush_pre_count: got %0d exp 5", bus.count); end
    bus.flush = 1'b1; bus.iss_ready = 1'b1;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 7'd3; bus.cdb_data = 32'h9;
    set_disp(7'd33, 7'd3, 32'd0, 1'b0, 7'd0, 32'd0, 1'b1);
    step();
    idle();
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d exp 0", bus.count); end
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL flush_iss_valid: got %0b exp 0", bus.iss_valid); end
    checks++; if (bus.disp_ready !== 1'b1) begin errors++; $display("FAIL flush_disp_ready: got %0b exp 1", bus.disp_ready); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      set_disp(7'(i), 7'd60, 32'd0, 1'b0, 7'd0, 32'd0, 1'b1);
      step();
    end
    bus.disp_valid = 1'b0;
    checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL rstmid_pre_count: got %0d exp 3", bus.count); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL rstmid_async_count: got %0d exp 0", bus.count); end
    step();
    reset = 1'b0;
    set_disp(7'd30, 7'd0, 32'h3, 1'b1, 7'd0, 32'h4, 1'b1);
    step();
    bus.disp_valid = 1'b0;
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL rstmid_count: got %0d exp 1", bus.count); end
    checks++; if (bus.iss_rd !== 7'd30) begin errors++; $display("FAIL rstmid_slot0: got %0d exp 30", bus.iss_rd); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_wakeup();
    test_full();
    test_bypass();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reservation_station_param.md
RESERVATION_STATION_PARAM -- requirements
Module: reservation_station_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (>=2).
REQ-002 SHALL have parameter TAG_W, default 7, register-tag width.
REQ-003 SHALL have parameter DATA_W, default 32, operand data width.
REQ-004 SHALL have parameter OPC_W, default 7, opcode width.
REQ-005 SHALL have parameter PC_W, default 32, PC width.
REQ-006 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  entry available.
- disp_opcode  in  OPC_W  opcode.
- disp_pc  in  PC_W  PC.
- disp_rd  in  TAG_W  destination tag.
- disp_src1_tag, disp_src2_tag  in  TAG_W  source tags.
- disp_src1_data, disp_src2_data  in  DATA_W  source values.
- disp_src1_rdy, disp_src2_rdy  in  1  source value valid.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast value.
- iss_valid  out  1  issue candidate present.
- iss_ready  in  1  execution unit accepts.
- iss_opcode  out  OPC_W  issued opcode.
- iss_pc  out  PC_W  issued PC.
- iss_rd  out  TAG_W  issued destination tag.
- iss_src1_data, iss_src2_data  out  DATA_W  issued operands.
- count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-007 Entries SHALL be held age-ordered: slot 0 oldest, slots 0..count-1 valid, no holes.
REQ-008 disp_ready SHALL be 1 iff count < DEPTH, derived from registered state only, not from iss_ready.
REQ-009 Dispatch fires when disp_valid && disp_ready at a rising edge. The new entry SHALL be written as the youngest entry: slot count, or slot count-1 if an issue fires in the same cycle.
REQ-010 Issue selection SHALL be combinational: the lowest-index valid entry with both sources ready. iss_valid SHALL be 1 iff such an entry exists. All iss_* fields SHALL be 0 when iss_valid = 0.
REQ-011 Issue fires when iss_valid && iss_ready at a rising edge. The selected entry SHALL be removed, and all higher entries SHALL shift down one slot, keeping their age order.
REQ-012 iss_* outputs SHALL hold stable while iss_valid && !iss_ready, unless an older entry becomes ready.
REQ-013 Wakeup: when cdb_valid = 1, every valid entry whose source is not ready and whose source tag == cdb_tag SHALL capture cdb_data and set that source ready. Both sources of one entry may wake in the same cycle.
REQ-014 Wakeup SHALL be registered. A woken entry is eligible for issue from the next cycle.
REQ-015 Dispatch bypass: a dispatching source with rdy = 0 and tag == cdb_tag while cdb_valid = 1 SHALL enter the station ready, with cdb_data.
REQ-016 A source with rdy = 1 SHALL never be overwritten by wakeup.
REQ-017 count SHALL update as follows: +1 on dispatch only, -1 on issue only, unchanged on both or neither. count SHALL never exceed DEPTH or go below 0.
REQ-018 Simultaneous issue and dispatch at count = DEPTH SHALL NOT occur, because disp_ready = 0 at that count.
REQ-019 flush = 1 SHALL invalidate all entries at the edge, leaving count = 0. flush SHALL take priority over dispatch, wakeup and issue in that cycle, and the iss handshake that cycle SHALL be discarded.
REQ-020 Wakeup on a shifting entry SHALL apply to that entry's new slot in the same edge, with no wakeup lost.

Reset
REQ-021 reset = 1 SHALL asynchronously clear all entry valid and ready state and set count = 0. Consequently iss_valid = 0, iss_* = 0 and disp_ready = 1.
REQ-022 reset asserted mid-operation SHALL discard all entries. The first dispatch after deassertion SHALL land in slot 0.

Verification
REQ-023 Scenario: reset, then dispatch src1 and src2 both ready, src1 = 5, src2 = 7, rd = 3, with iss_ready = 1. Required: iss_valid the next cycle with iss_src1_data = 5, iss_src2_data = 7, iss_rd = 3; count goes 1 then 0.
REQ-024 Scenario: dispatch entry A waiting on tag 9, then B both ready; later cdb tag 9 with data 0x1234. Required: B issues first; A issues the cycle after the wakeup with src = 0x1234.
REQ-025 Scenario: dispatch 16 entries, none ready. Required: count = 16, disp_ready = 0, and a 17th disp_valid is ignored; issuing one restores disp_ready = 1.
REQ-026 Scenario: cdb_valid with tag 4 in the same cycle as a dispatch with src2_tag 4 and rdy = 0. Required: entry enters ready with cdb_data and issues the next cycle.
REQ-027 Scenario: hold iss_ready = 0 for 3 cycles with a ready entry. Required: iss_* stable and count unchanged; accepted on the first iss_ready = 1.
REQ-028 Scenario: 5 entries, then assert flush together with disp_valid and cdb_valid. Required: count = 0 and iss_valid = 0 the next cycle.
